exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
- Execute stage directly downstream of the 16x16 register file read ports and upstream of its write port.
- Accepts one decoded operation with two operands (from read_data1/read_data2) and a destination address.
- Computes the result with single-cycle ALU ops, or iterative 16-step multiply/divide.
- Drives the register file's write_addr/write_data/write_enable for writeback, and holds a 4-bit status flag register.

Parameters:
- DATA_W, 16, operand/result width; also the multiply/divide iteration count.
- ADDR_W, 4, destination register address width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept (in_valid & in_ready = accept)
- opcode  in  4  operation select
- operand_a  in  DATA_W  first operand (read_data1)
- operand_b  in  DATA_W  second operand (read_data2)
- dest_addr  in  ADDR_W  writeback register
- flush  in  1  synchronous abort of in-flight op
- wb_enable  out  1  write strobe to register file
- wb_addr  out  ADDR_W  write address
- wb_data  out  DATA_W  write data
- flags  out  4  {Z,N,C,V}
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; wb_enable=0, wb_addr=0, wb_data=0, flags=0, busy=0, all internal regs 0. An in-flight op is dropped with no writeback.
- FSM states: IDLE, ITER, WB.
  - IDLE: accept -> WB for single-cycle ops; -> ITER for MUL/MULH/DIVU/REMU.
  - ITER: 16 cycles (counter 15..0), then -> WB.
  - WB: one cycle -> IDLE.
- in_ready = (state==IDLE) & ~flush.
- Operands, opcode and dest_addr are latched at accept; later input changes are ignored.
- Latency: accept at edge T.
  - Single-cycle op: wb_enable high in cycle after T.
  - Iterative op: wb_enable high in cycle after T+16 (17 cycles after accept).
  - Max throughput: one single-cycle op per 2 cycles.
- wb_enable is registered and high only in WB, for exactly one cycle. wb_addr/wb_data are valid while it is high and hold their values otherwise.
- Flags are updated at the same edge that enters WB.
- Opcodes (unsigned unless noted):
  - 0 ADD: C=carry out, V=signed overflow.
  - 1 SUB: A-B; C=1 when A>=B (no borrow); V=signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT A: C=V=0.
  - 6 SHL, 7 SHR logical, 8 SAR: shift amount B[3:0]; C=last bit shifted out; amount 0 -> result=A, C=0; V=0.
  - 9 MOV: result=B; C=V=0.
  - 10 CMP: SUB flags, no writeback (wb_enable stays 0 in WB).
  - 11 MUL: low 16 bits of 32-bit product.
  - 12 MULH: high 16 bits of 32-bit product.
  - 13 DIVU: quotient, restoring division.
  - 14 REMU: remainder.
  - 15 NOP: no writeback, flags unchanged.
- Z and N are computed from the 16-bit result for all ops except NOP.
- MUL/MULH/DIVU/REMU: C=0, V=0.
- Divide by zero (B=0): no iteration shortcut; the full 16 cycles still run. Quotient=0xFFFF, remainder=A, V=1.
- flush:
  - In ITER or WB: next state IDLE; wb_enable forced 0 in that cycle; flags not updated.
  - In IDLE: blocks acceptance.
  - Flush has priority over every other event.
- No forwarding or hazard detection: upstream stalls on busy. Writes to register 0 are allowed (no hardwired zero).
- Arithmetic uses DATA_W+1-bit internal sums for carry. The multiplier accumulator and divider remainder are 2*DATA_W wide.

Test Plan:
- ADD A=0x7FFF, B=0x0001, dest=3, accepted at T -> wb_enable=1 in cycle T+1, wb_addr=3, wb_data=0x8000, flags Z=0 N=1 C=0 V=1; in_ready=1 at T+2.
- MUL A=0x1234, B=0x0010 -> wb_data=0x2340 exactly 17 cycles after accept; busy high throughout. MULH with same operands -> 0x0001.
- DIVU A=0x0064, B=0x0007 -> 0x000E; REMU -> 0x0002. DIVU A=0x1234, B=0 -> 0xFFFF, V=1; REMU -> 0x1234.
- CMP A=5, B=5 -> Z=1 C=1 N=0 V=0, wb_enable never asserts. SHL A=0x8001, B=1 -> 0x0002, C=1. SHL with B=0 -> 0x8001, C=0.
- Start MUL, deassert resetn at iteration 8 -> all outputs 0 immediately, no wb after release, next ADD behaves normally.
- Start DIVU, pulse flush at iteration 5 -> IDLE next cycle, no wb_enable, flags unchanged. flush with in_valid in IDLE -> not accepted.

Source files
------------

// File: rtl/exec_unit.sv
// Execute stage between the register-file read ports and its write port.
// Single-cycle ALU ops plus 16-step shift-add multiply and restoring divide.
module exec_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              flush,
  output logic              wb_enable,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SAR  = 4'd8;
  localparam logic [3:0] OP_MOV  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_MULH = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;
  localparam logic [3:0] OP_NOP  = 4'd15;

  logic [1:0]          state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic                wb_en_q, wb_en_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [3:0]          flags_q, flags_d;

  logic [CNT_W-1:0]    shamt;
  logic [DATA_W:0]     sum_w, diff_w, shl_w, shr_w, sar_w;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_v;
  logic                accept, new_is_iter, new_writes;

  logic [DATA_W:0]     mul_sum, div_top, div_diff;
  logic                div_ge, iter_is_mul;
  logic [2*DATA_W-1:0] iter_next;
  logic [DATA_W-1:0]   iter_res;
  logic                iter_v;

  assign in_ready  = (state_q == ST_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE);
  // A flush arriving during WB suppresses the already-registered strobe.
  assign wb_enable = wb_en_q && !flush;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign flags     = flags_q;

  assign shamt       = operand_b[CNT_W-1:0];
  assign new_is_iter = (opcode == OP_MUL) || (opcode == OP_MULH) ||
                       (opcode == OP_DIVU) || (opcode == OP_REMU);
  assign new_writes  = (opcode != OP_CMP) && (opcode != OP_NOP);

  always_comb begin
    sum_w   = {1'b0, operand_a} + {1'b0, operand_b};
    diff_w  = {1'b0, operand_a} - {1'b0, operand_b};
    // Extra guard bit on each shift captures the last bit shifted out.
    shl_w   = {1'b0, operand_a} << shamt;
    shr_w   = {operand_a, 1'b0} >> shamt;
    sar_w   = $signed({operand_a, 1'b0}) >>> shamt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = sum_w[DATA_W-1:0];
        alu_c   = sum_w[DATA_W];
        alu_v   = (operand_a[DATA_W-1] == operand_b[DATA_W-1]) &&
                  (sum_w[DATA_W-1] != operand_a[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff_w[DATA_W-1:0];
        alu_c   = !diff_w[DATA_W];
        alu_v   = (operand_a[DATA_W-1] != operand_b[DATA_W-1]) &&
                  (diff_w[DATA_W-1] != operand_a[DATA_W-1]);
      end
      OP_AND: alu_res = operand_a & operand_b;
      OP_OR:  alu_res = operand_a | operand_b;
      OP_XOR: alu_res = operand_a ^ operand_b;
      OP_NOT: alu_res = ~operand_a;
      OP_SHL: begin
        alu_res = shl_w[DATA_W-1:0];
        alu_c   = shl_w[DATA_W];
      end
      OP_SHR: begin
        alu_res = shr_w[DATA_W:1];
        alu_c   = shr_w[0];
      end
      OP_SAR: begin
        alu_res = sar_w[DATA_W:1];
        alu_c   = sar_w[0];
      end
      OP_MOV: alu_res = operand_b;
      default: ;
    endcase
  end

  // acc_q is {hi, lo}: multiply keeps the multiplier in lo and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left.
  always_comb begin
    iter_is_mul = (op_q == OP_MUL) || (op_q == OP_MULH);
    mul_sum     = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                  (acc_q[0] ? {1'b0, a_q} : '0);
    div_top     = acc_q[2*DATA_W-1:DATA_W-1];
    div_ge      = (div_top >= {1'b0, b_q});
    div_diff    = div_top - {1'b0, b_q};
    if (iter_is_mul)
      iter_next = {mul_sum, acc_q[DATA_W-1:1]};
    else if (div_ge)
      iter_next = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    else
      iter_next = {acc_q[2*DATA_W-2:0], 1'b0};
    if ((op_q == OP_MULH) || (op_q == OP_REMU))
      iter_res = iter_next[2*DATA_W-1:DATA_W];
    else
      iter_res = iter_next[DATA_W-1:0];
    iter_v = !iter_is_mul && (b_q == '0);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    flags_d   = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = opcode;
          a_d    = operand_a;
          b_d    = operand_b;
          dest_d = dest_addr;
          if (new_is_iter) begin
            state_d = ST_ITER;
            cnt_d   = CNT_W'(DATA_W - 1);
            if ((opcode == OP_MUL) || (opcode == OP_MULH))
              acc_d = {{DATA_W{1'b0}}, operand_b};
            else
              acc_d = {{DATA_W{1'b0}}, operand_a};
          end else begin
            state_d = ST_WB;
            if (opcode != OP_NOP)
              flags_d = {(alu_res == '0), alu_res[DATA_W-1], alu_c, alu_v};
            if (new_writes) begin
              wb_en_d   = 1'b1;
              wb_addr_d = dest_addr;
              wb_data_d = alu_res;
            end
          end
        end
      end
      ST_ITER: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = iter_next;
          if (cnt_q == '0) begin
            state_d   = ST_WB;
            flags_d   = {(iter_res == '0), iter_res[DATA_W-1], 1'b0, iter_v};
            wb_en_d   = 1'b1;
            wb_addr_d = dest_q;
            wb_data_d = iter_res;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      dest_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      flags_q   <= flags_d;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU vectors, iterative ops, CMP/NOP,
// mid-operation reset, flush and back-to-back throughput.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = 4'd0;
  logic [15:0] operand_a = 16'd0;
  logic [15:0] operand_b = 16'd0;
  logic [3:0]  dest_addr = 4'd0;
  logic        flush = 1'b0;
  logic        wb_enable;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  flags;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;

  exec_unit #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .dest_addr(dest_addr), .flush(flush), .wb_enable(wb_enable),
    .wb_addr(wb_addr), .wb_data(wb_data), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Presents one op, returns 1ns after its accept edge with inputs scrambled.
  task automatic issue(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
    end
    in_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; dest_addr = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0; opcode = 4'd0;
    operand_a = 16'hA5A5; operand_b = 16'h5A5A; dest_addr = 4'hF;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    tests++; if (wb_enable !== 1'b0) begin fails++; $display("FAIL rst_wb_enable got=%b exp=0", wb_enable); end
    tests++; if (wb_addr !== 4'h0) begin fails++; $display("FAIL rst_wb_addr got=%h exp=0", wb_addr); end
    tests++; if (wb_data !== 16'h0) begin fails++; $display("FAIL rst_wb_data got=%h exp=0", wb_data); end
    tests++; if (flags !== 4'h0) begin fails++; $display("FAIL rst_flags got=%b exp=0000", flags); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_add();
    issue(4'd0, 16'h7FFF, 16'h0001, 4'd3);
    tests++; if (wb_enable !== 1'b1) begin fails++; $display("FAIL add_wb_enable got=%b exp=1", wb_enable); end
    tests++; if (wb_addr !== 4'd3) begin fails++; $display("FAIL add_wb_addr got=%h exp=3", wb_addr); end
    tests++; if (wb_data !== 16'h8000) begin fails++; $display("FAIL add_wb_data got=%h exp=8000", wb_data); end
    tests++; if (flags !== 4'b0101) begin fails++; $display("FAIL add_flags got=%b exp=0101", flags); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL add_in_ready_wb got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add_in_ready_next got=%b exp=1", in_ready); end
    tests++; if (wb_enable !== 1'b0) begin fails++; $display("FAIL add_wb_pulse got=%b exp=0", wb_enable); end
    tests++; if (wb_data !== 16'h8000) begin fails++; $display("FAIL add_wb_hold got=%h exp=8000", wb_data); end
  endtask

  task automatic test_alu_vectors();
    vec_t v[12];
    v[0]  = '{4'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100};
    v[1]  = '{4'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
    v[2]  = '{4'd3, 16'h0000, 16'h0000, 16'h0000, 4'b1000};
    v[3]  = '{4'd4, 16'hFFFF, 16'h00FF, 16'hFF00, 4'b0100};
    v[4]  = '{4'd5, 16'h0000, 16'h1234, 16'hFFFF, 4'b0100};
    v[5]  = '{4'd6, 16'h8001, 16'h0001, 16'h0002, 4'b0010};
    v[6]  = '{4'd6, 16'h8001, 16'h0000, 16'h8001, 4'b0100};
    v[7]  = '{4'd7, 16'h8001, 16'h0001, 16'h4000, 4'b0010};
    v[8]  = '{4'd8, 16'h8001, 16'h0004, 16'hF800, 4'b0100};
    v[9]  = '{4'd9, 16'h1234, 16'h0000, 16'h0000, 4'b1000};
    v[10] = '{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
    v[11] = '{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};
    for (int i = 0; i < 12; i++) begin
      issue(v[i].op, v[i].a, v[i].b, 4'(i));
      tests++; if (wb_enable !== 1'b1) begin fails++; $display("FAIL alu%0d_wb_enable got=%b exp=1", i, wb_enable); end
      tests++; if (wb_addr !== 4'(i)) begin fails++; $display("FAIL alu%0d_wb_addr got=%h exp=%h", i, wb_addr, 4'(i)); end
      tests++; if (wb_data !== v[i].r) begin fails++; $display("FAIL alu%0d_wb_data got=%h exp=%h", i, wb_data, v[i].r); end
      tests++; if (flags !== v[i].f) begin fails++; $display("FAIL alu%0d_flags got=%b exp=%b", i, flags, v[i].f); end
    end
  endtask

  task automatic test_cmp_nop();
    issue(4'd10, 16'h0005, 16'h0005, 4'd8);
    tests++; if (wb_enable !== 1'b0) begin fails++; $display("FAIL cmp_wb_enable got=%b exp=0", wb_enable); end
    tests++; if (flags !== 4'b1010) begin fails++; $display("FAIL cmp_flags got=%b exp=1010", flags); end
    tests++; if (wb_data !== 16'h7FFF) begin fails++; $display("FAIL cmp_wb_hold got=%h exp=7fff", wb_data); end
    issue(4'd15, 16'h0000, 16'h0000, 4'd9);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL nop_busy got=%b exp=1", busy); end
    tests++; if (wb_enable !== 1'b0) begin fails++; $display("FAIL nop_wb_enable got=%b exp=0", wb_enable); end
    tests++; if (flags !== 4'b1010) begin fails++; $display("FAIL nop_flags got=%b exp=1010", flags); end
  endtask

  task automatic test_iterative();
    vec_t v[8];
    int n;
    logic busy_bad;
    v[0] = '{4'd11, 16'h1234, 16'h0010, 16'h2340, 4'b0000};
    v[1] = '{4'd12, 16'h1234, 16'h0010, 16'h0001, 4'b0000};
    v[2] = '{4'd11, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000};
    v[3] = '{4'd12, 16'hFFFF, 16'hFFFF, 16'hFFFE, 4'b0100};
    v[4] = '{4'd13, 16'h0064, 16'h0007, 16'h000E, 4'b0000};
    v[5] = '{4'd14, 16'h0064, 16'h0007, 16'h0002, 4'b0000};
    v[6] = '{4'd13, 16'h1234, 16'h0000, 16'hFFFF, 4'b0101};
    v[7] = '{4'd14, 16'h1234, 16'h0000, 16'h1234, 4'b0001};
    for (int i = 0; i < 8; i++) begin
      issue(v[i].op, v[i].a, v[i].b, 4'(i + 4));
      n = 0;
      busy_bad = 1'b0;
      while (!wb_enable && n < 40) begin
        if (busy !== 1'b1) busy_bad = 1'b1;
        @(posedge clk); #1;
        n++;
      end
      tests++; if (n != 16) begin fails++; $display("FAIL it%0d_latency got=%0d exp=16", i, n); end
      tests++; if (busy_bad) begin fails++; $display("FAIL it%0d_busy got=0 exp=1", i); end
      tests++; if (wb_addr !== 4'(i + 4)) begin fails++; $display("FAIL it%0d_wb_addr got=%h exp=%h", i, wb_addr, 4'(i + 4)); end
      tests++; if (wb_data !== v[i].r) begin fails++; $display("FAIL it%0d_wb_data got=%h exp=%h", i, wb_data, v[i].r); end
      tests++; if (flags !== v[i].f) begin fails++; $display("FAIL it%0d_flags got=%b exp=%b", i, flags, v[i].f); end
    end
  endtask

  task automatic test_reset_mid();
    logic saw_wb;
    issue(4'd11, 16'h1234, 16'h0010, 4'd9);
    repeat (8) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    tests++; if (wb_enable !== 1'b0) begin fails++; $display("FAIL rmid_wb_enable got=%b exp=0", wb_enable); end
    tests++; if (wb_addr !== 4'h0) begin fails++; $display("FAIL rmid_wb_addr got=%h exp=0", wb_addr); end
    tests++; if (wb_data !== 16'h0) begin fails++; $display("FAIL rmid_wb_data got=%h exp=0", wb_data); end
    tests++; if (flags !== 4'h0) begin fails++; $display("FAIL rmid_flags got=%b exp=0000", flags); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    @(negedge clk);
    resetn = 1'b1;
    saw_wb = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (wb_enable !== 1'b0) saw_wb = 1'b1;
    end
    tests++; if (saw_wb) begin fails++; $display("FAIL rmid_no_wb got=1 exp=0"); end
    issue(4'd0, 16'h7FFF, 16'h0001, 4'd3);
    tests++; if (wb_enable !== 1'b1) begin fails++; $display("FAIL rmid_add_wb got=%b exp=1", wb_enable); end
    tests++; if (wb_data !== 16'h8000) begin fails++; $display("FAIL rmid_add_data got=%h exp=8000", wb_data); end
    tests++; if (flags !== 4'b0101) begin fails++; $display("FAIL rmid_add_flags got=%b exp=0101", flags); end
  endtask

  task automatic test_flush();
    logic saw_wb;
    issue(4'd13, 16'h0064, 16'h0007, 4'd6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fl_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fl_busy got=%b exp=0", busy); end
    tests++; if (flags !== 4'b0101) begin fails++; $display("FAIL fl_flags got=%b exp=0101", flags); end
    tests++; if (wb_data !== 16'h8000) begin fails++; $display("FAIL fl_wb_hold got=%h exp=8000", wb_data); end
    saw_wb = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (wb_enable !== 1'b0) saw_wb = 1'b1;
    end
    tests++; if (saw_wb) begin fails++; $display("FAIL fl_no_wb got=1 exp=0"); end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; opcode = 4'd0;
    operand_a = 16'h0001; operand_b = 16'h0001; dest_addr = 4'd7;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fl_idle_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fl_idle_busy got=%b exp=0", busy); end
    in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    tests++; if (wb_enable !== 1'b0) begin fails++; $display("FAIL fl_idle_wb got=%b exp=0", wb_enable); end
    tests++; if (wb_addr !== 4'd3) begin fails++; $display("FAIL fl_idle_addr got=%h exp=3", wb_addr); end
  endtask

  task automatic test_back_to_back();
    int c0;
    issue(4'd0, 16'h0001, 16'h0002, 4'd1);
    c0 = cyc;
    tests++; if (wb_data !== 16'h0003) begin fails++; $display("FAIL b2b_first got=%h exp=0003", wb_data); end
    issue(4'd1, 16'h0003, 16'h0004, 4'd2);
    tests++; if (cyc - c0 != 2) begin fails++; $display("FAIL b2b_spacing got=%0d exp=2", cyc - c0); end
    tests++; if (wb_enable !== 1'b1) begin fails++; $display("FAIL b2b_wb got=%b exp=1", wb_enable); end
    tests++; if (wb_data !== 16'hFFFF) begin fails++; $display("FAIL b2b_second got=%h exp=ffff", wb_data); end
    tests++; if (flags !== 4'b0100) begin fails++; $display("FAIL b2b_flags got=%b exp=0100", flags); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_vectors();
    test_cmp_nop();
    test_iterative();
    test_reset_mid();
    test_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
